// File: rtl/mix_columns_iter.sv
// AES MixColumns / InvMixColumns stage that rewrites the state register in place,
// COLS_PER_CYCLE columns per cycle, with valid/ready handshakes and a last-round bypass.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] shiftRowData,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         lastRound,
  input  logic         inverse,
  output logic [127:0] mixColData,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : gBadParam
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

  stateType     state;
  stateType     nextState;
  logic [127:0] dataReg;
  logic [127:0] transformed;
  logic [2:0]   cnt;
  logic         invReg;
  logic         lastGroup;

  // GF(2^8) doubling, reduced by 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulB(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mulD(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mulE(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // One column through the forward or inverse circulant matrix; row r is byte r
  function automatic logic [31:0] colTransform(input logic [31:0] col, input logic inv);
    logic [31:0] res;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [7:0]  a3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a0 = col[8*r +: 8];
      a1 = col[8*((r+1)%4) +: 8];
      a2 = col[8*((r+2)%4) +: 8];
      a3 = col[8*((r+3)%4) +: 8];
      if (inv) begin
        res[8*r +: 8] = mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3);
      end else begin
        res[8*r +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      end
    end
    return res;
  endfunction

  assign lastGroup  = (cnt + STEP) >= 3'd4;
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign mixColData = dataReg;

  // Only the column group selected by cnt is rewritten; the rest pass through
  always_comb begin
    transformed = dataReg;
    for (int c = 0; c < 4; c++) begin
      if (3'(c) >= cnt && 3'(c) < cnt + STEP) begin
        transformed[32*c +: 32] = colTransform(dataReg[32*c +: 32], invReg);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = lastRound ? DONE : BUSY;
      BUSY:    if (lastGroup) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Mode is captured only at accept, so the block in flight cannot change mode
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dataReg <= '0;
      cnt     <= '0;
      invReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dataReg <= shiftRowData;
            invReg  <= inverse;
            cnt     <= '0;
          end
        end
        BUSY: begin
          dataReg <= transformed;
          cnt     <= cnt + STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: one instance per legal COLS_PER_CYCLE,
// checked against a shift-and-add GF(2^8) matrix model plus the published AES vectors.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [127:0] din [3];
  logic         inValid [3];
  logic         lastR [3];
  logic         inv [3];
  logic         outReady [3];
  logic         inReady [3];
  logic         outValid [3];
  logic [127:0] dout [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .shiftRowData(din[0]), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .lastRound(lastR[0]), .inverse(inv[0]), .mixColData(dout[0]), .out_valid(outValid[0]),
    .out_ready(outReady[0]));

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .shiftRowData(din[1]), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .lastRound(lastR[1]), .inverse(inv[1]), .mixColData(dout[1]), .out_valid(outValid[1]),
    .out_ready(outReady[1]));

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .n_rst(n_rst), .shiftRowData(din[2]), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .lastRound(lastR[2]), .inverse(inv[2]), .mixColData(dout[2]), .out_valid(outValid[2]),
    .out_ready(outReady[2]));

  // Polynomial product followed by long division by 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s, input logic invMode);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (invMode) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], s[32*c + 8*((r+k)%4) +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitValid(input int idx, output int lat);
    lat = 0;
    while (outValid[idx] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction on instance idx; mode inputs are scrambled right after accept
  task automatic applyStimulus(input int idx, input logic [127:0] data, input logic last,
                               input logic invMode, input logic [127:0] exp,
                               output logic [127:0] result);
    int    lat;
    string pre;
    pre = $sformatf("cpc%0d", 1 << idx);
    checkOutput({pre, " in_ready idle"}, 128'(inReady[idx]), 128'd1);
    din[idx] = data; lastR[idx] = last; inv[idx] = invMode; inValid[idx] = 1'b1;
    @(posedge clk); #1;
    inValid[idx] = 1'b0;
    din[idx] = rand128(); lastR[idx] = ~last; inv[idx] = ~invMode;
    waitValid(idx, lat);
    checkOutput({pre, " latency"}, 128'(lat), last ? 128'd0 : 128'(4 >> idx));
    checkOutput({pre, " data"}, dout[idx], exp);
    checkOutput({pre, " in_ready done"}, 128'(inReady[idx]), 128'd0);
    result = dout[idx];
    outReady[idx] = 1'b1;
    @(posedge clk); #1;
    outReady[idx] = 1'b0;
    checkOutput({pre, " out_valid drop"}, 128'(outValid[idx]), 128'd0);
    checkOutput({pre, " in_ready back"}, 128'(inReady[idx]), 128'd1);
    checkOutput({pre, " data held"}, dout[idx], exp);
  endtask

  initial begin
    logic [127:0] vecA, expA, vecB, expB, x, y, r;
    int lat;
    vecA = {4{32'h455313db}};
    expA = {4{32'hbca14d8e}};
    vecB = 128'h4c31262d_c6c6c6c6_01010101_5c220af2;
    expB = 128'hf8bd7e4d_c6c6c6c6_01010101_9d58dc9f;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; inValid[i] = 1'b0; lastR[i] = 1'b0; inv[i] = 1'b0; outReady[i] = 1'b0;
    end
    n_rst = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset data %0d", i), dout[i], 128'd0);
      checkOutput($sformatf("reset out_valid %0d", i), 128'(outValid[i]), 128'd0);
      checkOutput($sformatf("reset in_ready %0d", i), 128'(inReady[i]), 128'd1);
    end
    #9 n_rst = 1'b1;
    @(posedge clk); #1;

    for (int idx = 0; idx < 3; idx++) begin
      applyStimulus(idx, vecA, 1'b0, 1'b0, expA, r);
      applyStimulus(idx, vecB, 1'b0, 1'b0, expB, r);
      applyStimulus(idx, expA, 1'b0, 1'b1, vecA, r);
      x = rand128();
      applyStimulus(idx, x, 1'b0, 1'b0, refMix(x, 1'b0), y);
      applyStimulus(idx, y, 1'b0, 1'b1, x, r);
      x = rand128();
      applyStimulus(idx, x, 1'b0, 1'b1, refMix(x, 1'b1), r);
      x = rand128();
      applyStimulus(idx, x, 1'b1, 1'($urandom), x, r);
    end

    // Back-pressure in DONE with a competing in_valid
    x = rand128();
    y = refMix(x, 1'b0);
    din[0] = x; lastR[0] = 1'b0; inv[0] = 1'b0; inValid[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = rand128();
    inValid[0] = 1'b0;
    waitValid(0, lat);
    checkOutput("stall latency", 128'(lat), 128'd4);
    inValid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("stall data %0d", k), dout[0], y);
      checkOutput($sformatf("stall out_valid %0d", k), 128'(outValid[0]), 128'd1);
      checkOutput($sformatf("stall in_ready %0d", k), 128'(inReady[0]), 128'd0);
    end
    outReady[0] = 1'b1;
    @(posedge clk); #1;
    outReady[0] = 1'b0;
    inValid[0] = 1'b0;
    checkOutput("stall release out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("stall release in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("stall release data", dout[0], y);

    // Asynchronous reset in the middle of BUSY
    din[0] = rand128(); inValid[0] = 1'b1;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    checkOutput("midreset out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("midreset data", dout[0], 128'd0);
    checkOutput("midreset in_ready", 128'(inReady[0]), 128'd1);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, vecB, 1'b0, 1'b0, expB, r);
    x = rand128();
    applyStimulus(0, x, 1'b0, 1'b1, refMix(x, 1'b1), r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
